// File: rtl/reg_file_sb.sv
// Register file with per-entry busy scoreboard and post-reset clear sweep; reads are combinational, writes land on the next edge.
// Optional write-to-read forwarding under REGFILE_BYPASS_EN; o_ready low (all writes/allocs ignored) until the sweep finishes.
module reg_file_sb #(
   parameter  int XLEN  = 32,
   parameter  int NREGS = 32,
   parameter  int NRP   = 2,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_re,
   input  logic [NRP*AW-1:0]   i_rs,
   output logic [NRP*XLEN-1:0] o_rdata,
   output logic [NRP-1:0]      o_rbusy,
   input  logic                i_wr,
   input  logic [AW-1:0]       i_rd,
   input  logic [XLEN-1:0]     i_wdata,
   input  logic                i_alloc,
   input  logic [AW-1:0]       i_alloc_rd,
   output logic                o_ready
);

   typedef enum logic {S_INIT, S_RUN} state_t;

   // One extra bit so the range check never degenerates into a constant compare
   localparam logic [AW:0]   LIMIT = (AW+1)'(NREGS);
   localparam logic [AW-1:0] LAST  = AW'(NREGS-1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [AW-1:0]     r_ptr;
   logic [AW-1:0]     w_ptr_nxt;
   logic              r_ready;
   logic [XLEN-1:0]   r_mem [NREGS];
   logic [NREGS-1:0]  r_busy;

   logic              w_run;
   logic              w_sweep_we;
   logic              w_wr_ok;
   logic              w_alloc_ok;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_INIT;
         r_ptr   <= AW'(1);
         r_ready <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_ready <= (w_state_nxt == S_RUN);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      if (r_state == S_INIT) begin
         w_ptr_nxt = r_ptr + AW'(1);
         if (r_ptr == LAST) w_state_nxt = S_RUN;
      end
   end

   always_comb begin
      w_run      = (r_state == S_RUN);
      w_sweep_we = (r_state == S_INIT);
   end

   assign o_ready    = r_ready;
   assign w_wr_ok    = w_run && i_wr && (i_rd != '0) && ({1'b0, i_rd} < LIMIT);
   assign w_alloc_ok = w_run && i_alloc && (i_alloc_rd != '0) && ({1'b0, i_alloc_rd} < LIMIT);

   // Storage has no reset; the sweep zeroes it instead
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (w_sweep_we)
            r_mem[r_ptr] <= '0;
         else if (w_wr_ok)
            r_mem[i_rd] <= i_wdata;
      end
   end

   // Alloc is checked first so a same-cycle write+alloc leaves the entry busy
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_busy <= '0;
      end else if (w_run) begin
         for (int i = 1; i < NREGS; i++) begin
            if (w_alloc_ok && (i_alloc_rd == AW'(i)))
               r_busy[i] <= 1'b1;
            else if (w_wr_ok && (i_rd == AW'(i)))
               r_busy[i] <= 1'b0;
         end
      end
   end

   for (genvar k = 0; k < NRP; k++) begin : g_rd
      logic [AW-1:0] w_rs;
      logic          w_valid;

      assign w_rs    = i_rs[k*AW +: AW];
      assign w_valid = w_run && (w_rs != '0) && ({1'b0, w_rs} < LIMIT);

`ifdef REGFILE_BYPASS_EN
      logic w_byp;
      assign w_byp = w_wr_ok && (i_rd == w_rs);
      assign o_rdata[k*XLEN +: XLEN] = (!i_re || !w_valid) ? '0 :
                                       w_byp ? i_wdata : r_mem[w_rs];
      assign o_rbusy[k] = w_valid &&
                          (w_byp ? (w_alloc_ok && (i_alloc_rd == w_rs)) : r_busy[w_rs]);
`else
      assign o_rdata[k*XLEN +: XLEN] = (!i_re || !w_valid) ? '0 : r_mem[w_rs];
      assign o_rbusy[k] = w_valid && r_busy[w_rs];
`endif
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: default instance (32 regs, 2 ports) plus a 24-reg, 3-port instance.
module tb_reg_file_sb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        re, wr, alloc, ready;
   logic [9:0]  rs;
   logic [63:0] rdata;
   logic [1:0]  rbusy;
   logic [4:0]  rd, alloc_rd;
   logic [31:0] wdata;

   logic        re2, wr2, alloc2, ready2;
   logic [14:0] rs2;
   logic [95:0] rdata2;
   logic [2:0]  rbusy2;
   logic [4:0]  rd2, alloc_rd2;
   logic [31:0] wdata2;

   reg_file_sb dut (
      .clk(clk), .rst_n(rst_n), .i_re(re), .i_rs(rs), .o_rdata(rdata), .o_rbusy(rbusy),
      .i_wr(wr), .i_rd(rd), .i_wdata(wdata), .i_alloc(alloc), .i_alloc_rd(alloc_rd),
      .o_ready(ready));

   reg_file_sb #(.XLEN(32), .NREGS(24), .NRP(3)) dut24 (
      .clk(clk), .rst_n(rst_n), .i_re(re2), .i_rs(rs2), .o_rdata(rdata2), .o_rbusy(rbusy2),
      .i_wr(wr2), .i_rd(rd2), .i_wdata(wdata2), .i_alloc(alloc2), .i_alloc_rd(alloc_rd2),
      .o_ready(ready2));

   int n_checks = 0;
   int n_fail   = 0;

   string       q_tag[$];
   logic [31:0] q_exp[$];

   logic [31:0] m_mem [32];
   bit          m_busy [32];
   bit          m_run = 1'b0;
   int          m_ptr = 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_val(input string tag, input logic [31:0] e);
      q_tag.push_back(tag);
      q_exp.push_back(e);
   endtask

   task automatic pop_chk(input logic [31:0] obs);
      string       t;
      logic [31:0] e;
      if (q_exp.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL sb_empty: got %h expected a queued entry", obs);
      end else begin
         t = q_tag.pop_front();
         e = q_exp.pop_front();
         check_eq(t, obs, e);
      end
   endtask

   function automatic logic [31:0] exp_data(input int k);
      int a = int'(rs[k*5 +: 5]);
      if (!re || a == 0 || !m_run) return 32'h0;
`ifdef REGFILE_BYPASS_EN
      if (wr && rd != 5'd0 && int'(rd) == a) return wdata;
`endif
      return m_mem[a];
   endfunction

   function automatic logic exp_busy(input int k);
      int a = int'(rs[k*5 +: 5]);
      if (a == 0 || !m_run) return 1'b0;
`ifdef REGFILE_BYPASS_EN
      if (wr && rd != 5'd0 && int'(rd) == a) return alloc && int'(alloc_rd) == a;
`endif
      return m_busy[a];
   endfunction

   // Reference model update for the default instance at the coming edge
   task automatic model_edge();
      if (!rst_n) begin
         m_run = 1'b0;
         m_ptr = 1;
         for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else if (!m_run) begin
         m_mem[m_ptr] = 32'h0;
         if (m_ptr == 31) m_run = 1'b1;
         m_ptr++;
      end else begin
         if (wr && rd != 5'd0) begin
            m_mem[rd]  = wdata;
            m_busy[rd] = 1'b0;
         end
         if (alloc && alloc_rd != 5'd0) m_busy[alloc_rd] = 1'b1;
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic cycle_check();
      for (int k = 0; k < 2; k++) begin
         expect_val($sformatf("rdata%0d", k), exp_data(k));
         expect_val($sformatf("rbusy%0d", k), {31'b0, exp_busy(k)});
      end
      expect_val("ready", {31'b0, m_run});
      #3;
      pop_chk(rdata[31:0]);
      pop_chk({31'b0, rbusy[0]});
      pop_chk(rdata[63:32]);
      pop_chk({31'b0, rbusy[1]});
      pop_chk({31'b0, ready});
   endtask

   task automatic check24(input logic [31:0] ed, input logic eb);
      for (int k = 0; k < 3; k++) begin
         expect_val($sformatf("n24_rdata%0d", k), ed);
         expect_val($sformatf("n24_rbusy%0d", k), {31'b0, eb});
      end
      #3;
      for (int k = 0; k < 3; k++) begin
         pop_chk(rdata2[k*32 +: 32]);
         pop_chk({31'b0, rbusy2[k]});
      end
   endtask

   task automatic wait_ready(input string tag);
      int cnt = 0;
      while (ready !== 1'b1 && cnt < 100) begin
         cycle_check();
         tick();
         cnt++;
      end
      check_eq(tag, cnt, 31);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) m_mem[i] = 32'hx;
      rst_n = 1'b0; re = 1'b1; rs = {5'd0, 5'd5}; wr = 1'b0; rd = '0; wdata = '0;
      alloc = 1'b0; alloc_rd = '0;
      re2 = 1'b0; rs2 = '0; wr2 = 1'b0; rd2 = '0; wdata2 = '0; alloc2 = 1'b0; alloc_rd2 = '0;
      tick();
      cycle_check();
      tick();
      check_eq("n24_ready_rst", {31'b0, ready2}, 32'd0);

      // Sweep after release
      rst_n = 1'b1;
      wait_ready("sweep_len");
      check_eq("n24_ready", {31'b0, ready2}, 32'd1);
      cycle_check();
      check_eq("x5_zero", rdata[31:0], 32'h0);

      // Plain write then read, x0 write ignored
      wr = 1'b1; rd = 5'd7; wdata = 32'hDEADBEEF;
      cycle_check();
      tick();
      wr = 1'b0; rs = {5'd0, 5'd7};
      cycle_check();
      check_eq("x7_data", rdata[31:0], 32'hDEADBEEF);
      tick();
      wr = 1'b1; rd = 5'd0; wdata = 32'hFFFF_FFFF;
      cycle_check();
      tick();
      wr = 1'b0; rs = {5'd7, 5'd0};
      cycle_check();
      check_eq("x0_zero", rdata[31:0], 32'h0);
      re = 1'b0;
      cycle_check();
      re = 1'b1;

      // Scoreboard: alloc, write clears, write+alloc keeps busy
      rs = {5'd0, 5'd3}; alloc = 1'b1; alloc_rd = 5'd3;
      cycle_check();
      tick();
      alloc = 1'b0;
      cycle_check();
      check_eq("x3_busy", {31'b0, rbusy[0]}, 32'd1);
      wr = 1'b1; rd = 5'd3; wdata = 32'h12;
      cycle_check();
      tick();
      wr = 1'b0;
      cycle_check();
      check_eq("x3_clear", {31'b0, rbusy[0]}, 32'd0);
      wr = 1'b1; rd = 5'd3; wdata = 32'h34; alloc = 1'b1; alloc_rd = 5'd3;
      cycle_check();
      tick();
      wr = 1'b0; alloc = 1'b0;
      cycle_check();
      check_eq("wa_busy", {31'b0, rbusy[0]}, 32'd1);
      check_eq("wa_data", rdata[31:0], 32'h34);
      alloc = 1'b1; alloc_rd = 5'd3;
      cycle_check();
      tick();
      alloc = 1'b0;
      cycle_check();
      check_eq("realloc_busy", {31'b0, rbusy[0]}, 32'd1);

      // Same-cycle read of a register being written
      rs = {5'd9, 5'd3}; wr = 1'b1; rd = 5'd9; wdata = 32'hA5A5;
      cycle_check();
`ifdef REGFILE_BYPASS_EN
      check_eq("byp_data", rdata[63:32], 32'hA5A5);
`else
      check_eq("byp_data", rdata[63:32], 32'h0);
`endif
      check_eq("byp_busy", {31'b0, rbusy[1]}, 32'd0);
      tick();
      wr = 1'b0;
      cycle_check();
      check_eq("x9_data", rdata[63:32], 32'hA5A5);

      // Reset in RUN, then again mid-sweep at cycle 10
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycle_check();
         tick();
      end
      rst_n = 1'b0;
      cycle_check();
      tick();
      cycle_check();
      rst_n = 1'b1;
      wait_ready("resweep_len");
      rs = {5'd7, 5'd3};
      cycle_check();
      check_eq("x3_busy_rst", {31'b0, rbusy[0]}, 32'd0);
      check_eq("x7_zero_rst", rdata[63:32], 32'h0);

      // Non-power-of-two instance: out-of-range accesses dropped
      check_eq("n24_ready2", {31'b0, ready2}, 32'd1);
      wr2 = 1'b1; rd2 = 5'd30; wdata2 = 32'hFF; alloc2 = 1'b1; alloc_rd2 = 5'd30;
      tick();
      wr2 = 1'b0; alloc2 = 1'b0; re2 = 1'b1; rs2 = {5'd30, 5'd30, 5'd30};
      check24(32'h0, 1'b0);
      rs2 = {5'd14, 5'd14, 5'd14};
      check24(32'h0, 1'b0);
      tick();
      wr2 = 1'b1; rd2 = 5'd23; wdata2 = 32'h2323;
      tick();
      wr2 = 1'b0; rs2 = {5'd23, 5'd23, 5'd23};
      check24(32'h2323, 1'b0);
      alloc2 = 1'b1; alloc_rd2 = 5'd23;
      tick();
      alloc2 = 1'b0;
      check24(32'h2323, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised successor to the core's integer register file. Provides XLEN-wide storage for NREGS entries, NRP asynchronous read ports and one synchronous write port. Adds a per-register scoreboard (busy bits) for the issue stage and a post-reset clear sweep, so storage needs no per-entry reset. Sits between decode/issue (reads, allocates) and writeback (writes).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of registers, 2..64; entry 0 is hard-wired zero
NRP, 2, number of read ports, 1..4
AW, $clog2(NREGS), address width; localparam, derived, not overridable

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
i_re  in  1  read enable, shared by all read ports
i_rs  in  NRP*AW  read addresses; port k at [k*AW +: AW]
o_rdata  out  NRP*XLEN  read data; port k at [k*XLEN +: XLEN]
o_rbusy  out  NRP  scoreboard busy flag for each read address
i_wr  in  1  write enable (writeback)
i_rd  in  AW  write address
i_wdata  in  XLEN  write data
i_alloc  in  1  mark a destination register pending (issue)
i_alloc_rd  in  AW  register to mark pending
o_ready  out  1  high once the clear sweep has finished

Behaviour:
- Reset: rst_n low at posedge -> state INIT, sweep pointer = 1, all busy bits = 0, o_ready = 0. Storage is not written in the reset cycle.
- Outputs during reset and INIT: o_rdata = 0, o_rbusy = 0 (combinational gating on state).
- FSM states: INIT and RUN.
  - INIT: each cycle writes 0 to entry[ptr] and increments ptr. The cycle that writes entry NREGS-1 moves the FSM to RUN.
  - So o_ready rises exactly NREGS-1 cycles after the first posedge with rst_n high (31 cycles at the defaults).
  - o_ready is registered and equals (state == RUN).
  - i_wr and i_alloc are ignored in INIT.
- Reset asserted mid-sweep or in RUN: returns to INIT with ptr = 1; the sweep restarts from the beginning.
- Write (RUN): i_wr and i_rd != 0 and i_rd < NREGS -> entry[i_rd] <= i_wdata and busy[i_rd] <= 0 on the next edge.
- Alloc (RUN): i_alloc and i_alloc_rd != 0 and i_alloc_rd < NREGS -> busy[i_alloc_rd] <= 1.
- Write and alloc to the same register in the same cycle: data is written and busy ends at 1 (new producer wins).
- Alloc of a register that is already busy: stays 1, with no error.
- Entry 0: never written, never busy; reads of entry 0 return 0.
- Read port k (combinational):
  - o_rdata = 0 if ~i_re, or rs == 0, or rs >= NREGS, or not in RUN.
  - Otherwise the bypass value (see Optional Feature) or entry[rs].
- o_rbusy[k]: 0 if rs == 0, rs >= NREGS, or not in RUN; otherwise busy[rs] (modified by the bypass rule when enabled). o_rbusy ignores i_re.
- Out-of-range addresses (NREGS not a power of two): writes and allocs are dropped; reads return 0 with busy 0.
- Any number of read ports may address the same register; every port sees identical results.

Optional Feature:
REGFILE_BYPASS_EN:
- Defined: write-to-read forwarding. If i_wr is active (RUN, i_rd != 0, in range) and rs == i_rd, o_rdata = i_wdata in the same cycle. o_rbusy[k] is forced to 0 unless i_alloc targets the same register in that cycle.
- Undefined: reads return the stored value. The written value is visible from the cycle after the write. o_rbusy reflects the registered busy bits only.

Test Plan:
1. Release rst_n, i_re = 1, rs0 = 5 -> o_ready = 0 and o_rdata = 0 for 31 cycles; o_ready = 1 on cycle 31; entry 5 reads 0.
2. RUN: write 0xDEADBEEF to x7, then read rs0 = 7, rs1 = 0 next cycle -> port0 = 0xDEADBEEF, port1 = 0; a write to x0 is ignored (x0 still reads 0).
3. Alloc x3 -> o_rbusy[0] = 1 for rs0 = 3. Write x3 = 0x12 -> busy clears the next cycle. Write and alloc x3 in the same cycle -> busy stays 1 and data = the new value.
4. With REGFILE_BYPASS_EN: write x9 = 0xA5A5 while rs1 = 9 -> port1 = 0xA5A5 and o_rbusy[1] = 0 in the same cycle. Without the macro: old value that cycle, 0xA5A5 the next cycle.
5. Assert rst_n low at sweep cycle 10 -> busy bits cleared and o_ready stays 0. The sweep restarts, and o_ready rises 31 cycles after release.
6. NREGS = 24, NRP = 3: write and alloc to x30 are dropped; reading x30 on all ports -> data 0, busy 0; reading x23 works normally.
